// File: rtl/tdm_delay_sched.sv
// Time-division delay scheduler: CH delay lines share one read-first single-port RAM,
// served round-robin one sample per cycle. `DELAY_SCHED_ZERO_FILL_EN zeroes unprimed outputs.
module tdm_delay_sched #(
  parameter int DW     = 8,
  parameter int CH     = 4,
  parameter int MAXLEN = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH-1:0]                in_valid,
  output logic [CH-1:0]                in_rdy,
  input  logic [CH*DW-1:0]             in_data,
  input  logic                         cfg_we,
  input  logic [$clog2(CH)-1:0]        cfg_ch,
  input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
  output logic                         out_valid,
  output logic [$clog2(CH)-1:0]        out_ch,
  output logic [DW-1:0]                out_data
);

  localparam int CW  = $clog2(CH);
  localparam int AW  = $clog2(CH*MAXLEN);
  localparam int LW  = $clog2(MAXLEN+1);
  localparam int CW1 = CW + 1;

  logic [CH-1:0] pending;
  logic [CH-1:0] gnt;
  logic [CH-1:0] acc;
  logic [DW-1:0] hold [CH];
  logic [LW-1:0] ptr  [CH];
  logic [LW-1:0] len  [CH];
  logic [CW-1:0] rr;
  logic [CW-1:0] idx;
  logic [CW-1:0] gnt_ch;
  logic          gnt_any;
  logic [AW-1:0] addr;
  logic          cfg_hit;
  logic [LW-1:0] cfg_len_c;
  logic          zero_out;
  logic [DW-1:0] mem [CH*MAXLEN];

  // rr holds the highest-priority channel for this cycle; no grants are issued during reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    if (rst_n) begin
      for (int unsigned k = 0; k < CH; k++) begin
        idx = CW'((32'(rr) + k) % CH);
        if (!gnt_any && pending[idx]) begin
          gnt_any = 1'b1;
          gnt_ch  = idx;
        end
      end
    end
  end

  assign gnt    = gnt_any ? (CH'(1) << gnt_ch) : '0;
  assign in_rdy = ~pending | gnt;
  assign acc    = in_valid & in_rdy;
  assign addr   = AW'(gnt_ch) * AW'(MAXLEN) + AW'(ptr[gnt_ch]);

  assign cfg_hit   = cfg_we && (CW1'(cfg_ch) < CW1'(CH));
  assign cfg_len_c = (cfg_len == '0)         ? LW'(1) :
                     (cfg_len > LW'(MAXLEN)) ? LW'(MAXLEN) : cfg_len;

`ifdef DELAY_SCHED_ZERO_FILL_EN
  logic [LW-1:0] fill [CH];
  assign zero_out = fill[gnt_ch] < len[gnt_ch];
`else
  assign zero_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      mem[addr] <= hold[gnt_ch];
    end
    for (int unsigned i = 0; i < CH; i++) begin
      if (acc[i]) begin
        hold[i] <= in_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      rr        <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        ptr[i] <= '0;
        len[i] <= LW'(MAXLEN);
`ifdef DELAY_SCHED_ZERO_FILL_EN
        fill[i] <= '0;
`endif
      end
    end else begin
      pending   <= acc | (pending & ~gnt);
      out_valid <= gnt_any;
      if (gnt_any) begin
        rr       <= (gnt_ch == CW'(CH-1)) ? '0 : gnt_ch + 1'b1;
        out_ch   <= gnt_ch;
        out_data <= zero_out ? '0 : mem[addr];
        ptr[gnt_ch] <= (ptr[gnt_ch] < len[gnt_ch] - LW'(1)) ? ptr[gnt_ch] + LW'(1) : '0;
`ifdef DELAY_SCHED_ZERO_FILL_EN
        fill[gnt_ch] <= (fill[gnt_ch] < len[gnt_ch]) ? fill[gnt_ch] + LW'(1) : len[gnt_ch];
`endif
      end
      // Placed after the grant update so a coincident config wins for ptr/len/fill
      if (cfg_hit) begin
        len[cfg_ch] <= cfg_len_c;
        ptr[cfg_ch] <= '0;
`ifdef DELAY_SCHED_ZERO_FILL_EN
        fill[cfg_ch] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tdm_delay_sched.sv
// Directed bench for tdm_delay_sched: vector table for single/all-channel streaming and
// mid-stream reconfiguration, hand sequences for clamping, default length and reset.
module tb_tdm_delay_sched;

`ifdef DELAY_SCHED_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_rdy;
  logic [31:0] in_data;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [5:0]  cfg_len;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;

  int total;
  int bad;
  logic [7:0] cap [64];
  int cap_n;

  tdm_delay_sched #(.DW(8), .CH(4), .MAXLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rdy(in_rdy), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_len(cfg_len),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic        cw;
    logic [1:0]  cc;
    logic [5:0]  cl;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  och;
    logic [7:0]  od;
    logic        chk;
  } row_t;

  row_t tab [$];

  function automatic row_t mk(input logic [3:0] v, input logic [31:0] d, input logic r,
                              input logic cw, input logic [1:0] cc, input logic [5:0] cl,
                              input logic [3:0] rdy, input logic ov, input logic [1:0] och,
                              input logic [7:0] od, input logic chk);
    row_t x;
    x.v = v; x.d = d; x.r = r; x.cw = cw; x.cc = cc; x.cl = cl;
    x.rdy = rdy; x.ov = ov; x.och = och; x.od = od; x.chk = chk;
    return x;
  endfunction

  function automatic row_t cfgrow(input logic [1:0] cc, input logic [5:0] cl);
    return mk(4'b0, 32'h0, 1'b1, 1'b1, cc, cl, 4'b1111, 1'b0, 2'd0, 8'h00, 1'b1);
  endfunction

  function automatic row_t dat(input logic [3:0] v, input logic [31:0] d, input logic [3:0] rdy,
                               input logic ov, input logic [1:0] och, input logic [7:0] od,
                               input logic chk);
    return mk(v, d, 1'b1, 1'b0, 2'd0, 6'd0, rdy, ov, och, od, chk);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [5:0] l);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = ch; cfg_len = l;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic stream(input int ch, input int n, input logic [7:0] base);
    logic [7:0] b;
    cap_n = 0;
    for (int c = 0; c < n + 4; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_ch == 2'(ch)) begin
        if (cap_n < 64) cap[cap_n] = out_data;
        cap_n++;
      end
      b = base + 8'(c);
      in_valid = (c < n) ? (4'b0001 << ch) : 4'b0000;
      in_data  = {4{b}};
    end
    in_valid = 4'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = '0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_len = '0;

    // ch0 alone, len 3
    tab.push_back(cfgrow(2'd0, 6'd3));
    tab.push_back(dat(4'b0001, 32'h01, 4'b1111, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b0001, 32'h02, 4'b1111, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b0001, 32'h03, 4'b1111, 1, 0, 8'h00, ZF));
    tab.push_back(dat(4'b0001, 32'h04, 4'b1111, 1, 0, 8'h00, ZF));
    tab.push_back(dat(4'b0001, 32'h05, 4'b1111, 1, 0, 8'h00, ZF));
    tab.push_back(dat(4'b0000, 32'h00, 4'b1111, 1, 0, 8'h01, 1));
    tab.push_back(dat(4'b0000, 32'h00, 4'b1111, 1, 0, 8'h02, 1));
    tab.push_back(mk(4'b0, 32'h0, 1'b0, 1'b0, 2'd0, 6'd0, 4'b1111, 0, 0, 8'h02, 1));
    // all four channels, len 1 each
    tab.push_back(cfgrow(2'd0, 6'd1));
    tab.push_back(cfgrow(2'd1, 6'd1));
    tab.push_back(cfgrow(2'd2, 6'd1));
    tab.push_back(cfgrow(2'd3, 6'd1));
    tab.push_back(dat(4'b1111, 32'h30201000, 4'b1111, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b1111, 32'h31211101, 4'b0001, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b1111, 32'h31211102, 4'b0010, 1, 0, 8'h00, ZF));
    tab.push_back(dat(4'b1111, 32'h31211202, 4'b0100, 1, 1, 8'h00, ZF));
    tab.push_back(dat(4'b1111, 32'h31221202, 4'b1000, 1, 2, 8'h00, ZF));
    tab.push_back(dat(4'b1111, 32'h32221202, 4'b0001, 1, 3, 8'h00, ZF));
    tab.push_back(dat(4'b1111, 32'h32221203, 4'b0010, 1, 0, 8'h00, 1));
    tab.push_back(dat(4'b1111, 32'h32221303, 4'b0100, 1, 1, 8'h10, 1));
    tab.push_back(dat(4'b1111, 32'h32231303, 4'b1000, 1, 2, 8'h20, 1));
    tab.push_back(dat(4'b1111, 32'h33231303, 4'b0001, 1, 3, 8'h30, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b0010, 1, 0, 8'h01, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b0110, 1, 1, 8'h11, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1110, 1, 2, 8'h21, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1111, 1, 3, 8'h31, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1111, 1, 0, 8'h02, 1));
    tab.push_back(mk(4'b0, 32'h0, 1'b0, 1'b0, 2'd0, 6'd0, 4'b1111, 0, 0, 8'h02, 1));
    // ch2 len 5, shortened to 2 in the same cycle as a grant
    tab.push_back(cfgrow(2'd2, 6'd5));
    tab.push_back(dat(4'b0100, 32'h00410000, 4'b1111, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b0100, 32'h00420000, 4'b1111, 0, 0, 8'h00, 0));
    tab.push_back(dat(4'b0100, 32'h00430000, 4'b1111, 1, 2, 8'h00, ZF));
    tab.push_back(dat(4'b0100, 32'h00440000, 4'b1111, 1, 2, 8'h00, ZF));
    tab.push_back(mk(4'b0100, 32'h00450000, 1'b1, 1'b1, 2'd2, 6'd2, 4'b1111, 1, 2, 8'h00, ZF));
    tab.push_back(dat(4'b0100, 32'h00460000, 4'b1111, 1, 2, 8'h00, ZF));
    tab.push_back(dat(4'b0100, 32'h00470000, 4'b1111, 1, 2, ZF ? 8'h00 : 8'h41, 1));
    tab.push_back(dat(4'b0100, 32'h00480000, 4'b1111, 1, 2, ZF ? 8'h00 : 8'h42, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1111, 1, 2, 8'h45, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1111, 1, 2, 8'h46, 1));
    tab.push_back(dat(4'b0000, 32'h0, 4'b1111, 0, 2, 8'h46, 1));

    repeat (3) @(posedge clk);
    #1;
    check("reset in_rdy", 32'(in_rdy), 32'hF);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset out_ch", 32'(out_ch), 32'h0);

    foreach (tab[i]) begin
      @(posedge clk); #1;
      check($sformatf("row%0d in_rdy", i), 32'(in_rdy), 32'(tab[i].rdy));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tab[i].ov));
      if (tab[i].ov) check($sformatf("row%0d out_ch", i), 32'(out_ch), 32'(tab[i].och));
      if (tab[i].chk) check($sformatf("row%0d out_data", i), 32'(out_data), 32'(tab[i].od));
      rst_n = tab[i].r; in_valid = tab[i].v; in_data = tab[i].d;
      cfg_we = tab[i].cw; cfg_ch = tab[i].cc; cfg_len = tab[i].cl;
    end

    // cfg_len 0 behaves as 1
    cfg(2'd1, 6'd0);
    stream(1, 4, 8'h50);
    check("len0 count", 32'(cap_n), 32'd4);
    check("len0 out1", 32'(cap[1]), 32'h50);
    check("len0 out2", 32'(cap[2]), 32'h51);
    check("len0 out3", 32'(cap[3]), 32'h52);
`ifdef DELAY_SCHED_ZERO_FILL_EN
    check("len0 prime", 32'(cap[0]), 32'h00);
`endif

    // cfg_len 40 clamps to 32
    cfg(2'd1, 6'd40);
    stream(1, 34, 8'h60);
    check("len40 count", 32'(cap_n), 32'd34);
    check("len40 out32", 32'(cap[32]), 32'h60);
    check("len40 out33", 32'(cap[33]), 32'h61);
`ifdef DELAY_SCHED_ZERO_FILL_EN
    check("len40 prime31", 32'(cap[31]), 32'h00);
`endif

    // reset restores default length MAXLEN
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    stream(3, 34, 8'h80);
    check("deflen count", 32'(cap_n), 32'd34);
    check("deflen out32", 32'(cap[32]), 32'h80);
    check("deflen out33", 32'(cap[33]), 32'h81);

    // reset while three channels are pending
    @(posedge clk); #1;
    in_valid = 4'b0111; in_data = 32'h00A3A2A1;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 4'b0;
    @(posedge clk); #1;
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst in_rdy", 32'(in_rdy), 32'hF);
    check("midrst out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst out_valid+1", 32'(out_valid), 32'h0);
    check("midrst in_rdy+1", 32'(in_rdy), 32'hF);
    @(posedge clk); #1;
    check("midrst out_valid+2", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
